sdram_host_sequencer: RTL and testbench

- Synthesisable host-side command sequencer for the SDRAM controller; it replaces hand-written stimulus.
- Issues READ/WRITE/REFRESH commands through the CMD/CMDACK handshake and streams write bursts ending in W_DATAEND.
- Captures and checks read bursts against a deterministic pattern.
- Sits between the on-chip test/BIST logic and the controller's host port.

---
 rtl/sdram_host_pkg.sv | 31 +++
 rtl/sdram_burst_checker.sv | 75 +++++++
 rtl/sdram_host_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sdram_host_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_host_pkg.sv
// Shared types and the read/write data pattern for the SDRAM host sequencer.
package sdram_host_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_READ    = 3'b001,
        CMD_WRITE   = 3'b010,
        CMD_REFRESH = 3'b011
    } cmd_e;

    typedef enum logic [1:0] {
        MODE_WR_RD = 2'b00,
        MODE_WR    = 2'b01,
        MODE_RD    = 2'b10,
        MODE_REF   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ACK, S_WDATA, S_RDATA, S_NEXT, S_PHASE, S_FIN
    } seq_state_e;

    localparam int PAT_W = 64;

    // Computed wide; callers truncate to DATA_W, which matches a DATA_W-wide sum.
    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                             input logic [PAT_W-1:0] a,
                                             input logic [PAT_W-1:0] b);
        return seed ^ (a + b);
    endfunction

endpackage

// File: rtl/sdram_burst_checker.sv
// Read-burst checker: beat counter, pattern compare, saturating error count.
// Optional first-mismatch log under SDRAM_SEQ_ERR_LOG_EN.
module sdram_burst_checker
    import sdram_host_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 16,
    localparam int BW       = $clog2(BURST_LEN)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              clr,
    input  logic              en,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] seed,
    output logic              burst_done,
`ifdef SDRAM_SEQ_ERR_LOG_EN
    output logic [ADDR_W-1:0] err_addr,
    output logic [BW-1:0]     err_beat,
    output logic [DATA_W-1:0] err_data,
    output logic              err_valid,
`endif
    output logic [CNT_W-1:0]  err_count
);

    logic [BW-1:0]     beat;
    logic [DATA_W-1:0] expect_d;
    logic              hit, mismatch;

    assign hit        = en && valid;
    assign expect_d   = DATA_W'(pat(PAT_W'(seed), PAT_W'(addr), PAT_W'(beat)));
    assign mismatch   = hit && (data != expect_d);
    assign burst_done = hit && (beat == BW'(BURST_LEN-1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            beat      <= '0;
            err_count <= '0;
        end else if (clr) begin
            beat      <= '0;
            err_count <= '0;
        end else begin
            if (hit)
                beat <= burst_done ? '0 : beat + 1'b1;
            if (mismatch && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

`ifdef SDRAM_SEQ_ERR_LOG_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_addr  <= '0;
            err_beat  <= '0;
            err_data  <= '0;
            err_valid <= 1'b0;
        end else if (clr) begin
            err_addr  <= '0;
            err_beat  <= '0;
            err_data  <= '0;
            err_valid <= 1'b0;
        end else if (mismatch && !err_valid) begin
            err_addr  <= addr;
            err_beat  <= beat;
            err_data  <= data;
            err_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/sdram_host_sequencer.sv
// Host-side SDRAM command sequencer: write/read-check/refresh bursts via CMD/CMDACK.
// Define SDRAM_SEQ_ERR_LOG_EN to add the first-mismatch error log outputs.
module sdram_host_sequencer
    import sdram_host_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 8,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 1024,
    localparam int BW         = $clog2(BURST_LEN),
    localparam int TW         = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bursts,
    input  logic [DATA_W-1:0] seed,
    output logic [2:0]        CMD,
    output logic [ADDR_W-1:0] ADDR,
    input  logic              CMDACK,
    output logic [DATA_W-1:0] DATAIN,
    output logic              W_DATAEND,
    input  logic [DATA_W-1:0] DATAOUT,
    input  logic              DATAOUT_VALID,
    output logic              busy,
    output logic              done,
    output logic              timeout,
`ifdef SDRAM_SEQ_ERR_LOG_EN
    output logic [ADDR_W-1:0] err_addr,
    output logic [BW-1:0]     err_beat,
    output logic [DATA_W-1:0] err_data,
    output logic              err_valid,
`endif
    output logic [CNT_W-1:0]  err_count
);

    seq_state_e        state, nxt;
    mode_e             mode_r;
    logic [ADDR_W-1:0] base_r, cur_addr;
    logic [CNT_W-1:0]  num_r, remaining;
    logic [DATA_W-1:0] seed_r;
    logic              rd_phase, timeout_r;
    logic [BW-1:0]     wbeat;
    logic [TW-1:0]     ack_cnt;
    logic              go, ack_expired, wlast, rd_done, reload;
    cmd_e              cur_cmd;

    assign go          = (state == S_IDLE) && start;
    assign ack_expired = (ack_cnt == TW'(ACK_TIMEOUT - 1));
    assign wlast       = (state == S_WDATA) && (wbeat == BW'(BURST_LEN - 1));
    assign reload      = (mode_r == MODE_WR_RD) && !rd_phase;
    assign cur_cmd     = (mode_r == MODE_REF) ? CMD_REFRESH :
                         rd_phase             ? CMD_READ    : CMD_WRITE;
    assign timeout     = timeout_r;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = (num_bursts == '0) ? S_FIN : S_ISSUE;
            S_ISSUE: if (CMDACK) nxt = S_ACK;
                     else if (ack_expired) nxt = S_FIN;
            S_ACK:   nxt = (mode_r == MODE_REF) ? S_NEXT :
                           rd_phase             ? S_RDATA : S_WDATA;
            S_WDATA: if (wlast) nxt = S_NEXT;
            S_RDATA: if (rd_done) nxt = S_NEXT;
            S_NEXT:  nxt = (remaining != CNT_W'(1)) ? S_ISSUE : S_PHASE;
            S_PHASE: nxt = reload ? S_ISSUE : S_FIN;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CMD       = CMD_NOP;
        ADDR      = '0;
        DATAIN    = '0;
        W_DATAEND = 1'b0;
        busy      = (state != S_IDLE) && (state != S_FIN);
        done      = (state == S_FIN);
        case (state)
            S_ISSUE: begin
                CMD  = cur_cmd;
                ADDR = cur_addr;
            end
            S_WDATA: begin
                DATAIN    = DATA_W'(pat(PAT_W'(seed_r), PAT_W'(cur_addr), PAT_W'(wbeat)));
                W_DATAEND = wlast;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_r    <= MODE_WR_RD;
            base_r    <= '0;
            cur_addr  <= '0;
            num_r     <= '0;
            remaining <= '0;
            seed_r    <= '0;
            rd_phase  <= 1'b0;
            timeout_r <= 1'b0;
            wbeat     <= '0;
            ack_cnt   <= '0;
        end else begin
            ack_cnt <= (state == S_ISSUE) ? ack_cnt + 1'b1 : '0;
            if (go) begin
                mode_r    <= mode_e'(mode);
                base_r    <= base_addr;
                cur_addr  <= base_addr;
                num_r     <= num_bursts;
                remaining <= num_bursts;
                seed_r    <= seed;
                rd_phase  <= (mode_e'(mode) == MODE_RD);
                timeout_r <= 1'b0;
                wbeat     <= '0;
            end
            if ((state == S_ISSUE) && ack_expired && !CMDACK)
                timeout_r <= 1'b1;
            if (state == S_WDATA)
                wbeat <= wlast ? '0 : wbeat + 1'b1;
            if (state == S_NEXT) begin
                cur_addr  <= cur_addr + ADDR_W'(BURST_LEN);
                remaining <= remaining - 1'b1;
            end
            // Write half of a write-then-check run done: rewind for the read half.
            if ((state == S_PHASE) && reload) begin
                cur_addr  <= base_r;
                remaining <= num_r;
                rd_phase  <= 1'b1;
            end
        end
    end

    sdram_burst_checker #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_chk (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .clr        (go),
        .en         (state == S_RDATA),
        .valid      (DATAOUT_VALID),
        .data       (DATAOUT),
        .addr       (cur_addr),
        .seed       (seed_r),
        .burst_done (rd_done),
`ifdef SDRAM_SEQ_ERR_LOG_EN
        .err_addr   (err_addr),
        .err_beat   (err_beat),
        .err_data   (err_data),
        .err_valid  (err_valid),
`endif
        .err_count  (err_count)
    );

endmodule

// File: tb/tb_sdram_host_sequencer.sv
// Directed bench for sdram_host_sequencer with a small echoing controller/memory model.
module tb_sdram_host_sequencer;

    localparam int BL = 8;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic [31:0] seed;
    logic [2:0]  CMD;
    logic [31:0] ADDR;
    logic        CMDACK;
    logic [31:0] DATAIN;
    logic        W_DATAEND;
    logic [31:0] DATAOUT;
    logic        DATAOUT_VALID;
    logic        busy, done, timeout;
    logic [15:0] err_count;
`ifdef SDRAM_SEQ_ERR_LOG_EN
    logic [31:0] err_addr;
    logic [2:0]  err_beat;
    logic [31:0] err_data;
    logic        err_valid;
`endif

    always #5 CLK = ~CLK;

    sdram_host_sequencer #(
        .ADDR_W(32), .DATA_W(32), .BURST_LEN(BL), .CNT_W(16), .ACK_TIMEOUT(16)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .mode(mode),
        .base_addr(base_addr), .num_bursts(num_bursts), .seed(seed),
        .CMD(CMD), .ADDR(ADDR), .CMDACK(CMDACK), .DATAIN(DATAIN),
        .W_DATAEND(W_DATAEND), .DATAOUT(DATAOUT), .DATAOUT_VALID(DATAOUT_VALID),
        .busy(busy), .done(done), .timeout(timeout),
`ifdef SDRAM_SEQ_ERR_LOG_EN
        .err_addr(err_addr), .err_beat(err_beat), .err_data(err_data), .err_valid(err_valid),
`endif
        .err_count(err_count)
    );

    int asserts = 0;
    int fails   = 0;

    // controller / memory model knobs and logs
    int          ack_dly = 3;
    logic        ack_en  = 1'b1;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    int          corrupt_beat = 0;
    logic [31:0] mem [logic [31:0]];
    logic [2:0]  cmd_q [$];
    logic [31:0] addr_q [$];

    // per-cycle traces of one sequence, index 1 = first cycle after start
    logic [2:0]  cmd_t  [0:127];
    logic [31:0] addr_t [0:127];
    logic [31:0] dat_t  [0:127];
    logic        end_t  [0:127];
    logic        busy_t [0:127];
    logic        to_t   [0:127];
    int          done_cycle;

    initial begin
        int          m_cnt, m_wleft, m_rleft, m_idx;
        logic        m_skip;
        logic [31:0] m_addr, a, d;
        m_cnt = 0; m_wleft = 0; m_rleft = 0; m_idx = 0; m_skip = 1'b0; m_addr = '0;
        CMDACK = 1'b0; DATAOUT = '0; DATAOUT_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            CMDACK = 1'b0; DATAOUT_VALID = 1'b0; DATAOUT = '0;
            if (!RESET_N) begin
                m_cnt = 0; m_wleft = 0; m_rleft = 0;
            end else if (m_wleft > 0) begin
                if (m_skip) m_skip = 1'b0;
                else begin
                    a = m_addr + m_idx;
                    mem[a] = DATAIN;
                    m_idx++; m_wleft--;
                end
            end else if (m_rleft > 0) begin
                if (m_skip) m_skip = 1'b0;
                else begin
                    a = m_addr + m_idx;
                    d = mem.exists(a) ? mem[a] : '0;
                    if (corrupt_en && m_addr == corrupt_addr && m_idx == corrupt_beat)
                        d = d ^ 32'h1;
                    DATAOUT = d; DATAOUT_VALID = 1'b1;
                    m_idx++; m_rleft--;
                end
            end else if (ack_en && CMD != 3'b000) begin
                m_cnt++;
                if (m_cnt >= ack_dly) begin
                    CMDACK = 1'b1; m_cnt = 0;
                    cmd_q.push_back(CMD); addr_q.push_back(ADDR);
                    m_addr = ADDR; m_idx = 0; m_skip = 1'b1;
                    if (CMD == 3'b010) m_wleft = BL;
                    else if (CMD == 3'b001) m_rleft = BL;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    task automatic run_seq(input logic [1:0] m, input logic [31:0] b, input logic [15:0] n,
                           input logic [31:0] s, input int budget);
        cmd_q.delete(); addr_q.delete();
        done_cycle = -1;
        @(negedge CLK);
        mode = m; base_addr = b; num_bursts = n; seed = s; start = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            start = 1'b0;
            cmd_t[i] = CMD; addr_t[i] = ADDR; dat_t[i] = DATAIN;
            end_t[i] = W_DATAEND; busy_t[i] = busy; to_t[i] = timeout;
            if (done) begin
                done_cycle = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0; num_bursts = '0; seed = '0;
        repeat (2) @(negedge CLK);
        asserts++;
        if ({CMD, ADDR, DATAIN, W_DATAEND} !== '0)
            begin fails++; $display("FAIL reset_bus: got CMD=%h ADDR=%h DATAIN=%h END=%b want all 0", CMD, ADDR, DATAIN, W_DATAEND); end
        asserts++;
        if ({busy, done, timeout, err_count} !== '0)
            begin fails++; $display("FAIL reset_status: got busy=%b done=%b to=%b err=%0d want 0", busy, done, timeout, err_count); end
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write_only;
        run_seq(2'b01, 32'hFFFF0000, 16'd1, 32'h0, 100);
        asserts++;
        if (done_cycle !== 15) begin fails++; $display("FAIL wr_done_cycle: got %0d want 15", done_cycle); end
        asserts++;
        if (cmd_t[1] !== 3'b010 || cmd_t[3] !== 3'b010 || addr_t[2] !== 32'hFFFF0000)
            begin fails++; $display("FAIL wr_cmd_hold: got %h/%h addr %h want 2/2 FFFF0000", cmd_t[1], cmd_t[3], addr_t[2]); end
        asserts++;
        if (cmd_t[4] !== 3'b000) begin fails++; $display("FAIL wr_cmd_nop: got %h want 0", cmd_t[4]); end
        for (int b = 0; b < BL; b++) begin
            asserts++;
            if (dat_t[5+b] !== 32'hFFFF0000 + b || end_t[5+b] !== (b == BL-1))
                begin fails++; $display("FAIL wr_beat%0d: got %h end=%b want %h end=%b", b, dat_t[5+b], end_t[5+b], 32'hFFFF0000 + b, (b == BL-1)); end
        end
        asserts++;
        if (dat_t[13] !== 32'h0 || end_t[13] !== 1'b0)
            begin fails++; $display("FAIL wr_after: got %h end=%b want 0 0", dat_t[13], end_t[13]); end
        asserts++;
        if (busy_t[1] !== 1'b1 || busy_t[15] !== 1'b0 || err_count !== 16'd0)
            begin fails++; $display("FAIL wr_status: busy %b/%b err %0d want 1/0 0", busy_t[1], busy_t[15], err_count); end
        @(negedge CLK);
        asserts++;
        if (done !== 1'b0) begin fails++; $display("FAIL wr_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_wr_rd;
        run_seq(2'b00, 32'hFFFF0000, 16'd2, 32'h12345678, 100);
        asserts++;
        if (done_cycle !== 55) begin fails++; $display("FAIL wrrd_done_cycle: got %0d want 55", done_cycle); end
        asserts++;
        if (cmd_q.size() != 4) begin fails++; $display("FAIL wrrd_ncmd: got %0d want 4", cmd_q.size()); end
        else begin
            asserts++;
            if (cmd_q[0] !== 3'b010 || cmd_q[1] !== 3'b010 || cmd_q[2] !== 3'b001 || cmd_q[3] !== 3'b001)
                begin fails++; $display("FAIL wrrd_cmds: got %h %h %h %h want 2 2 1 1", cmd_q[0], cmd_q[1], cmd_q[2], cmd_q[3]); end
            asserts++;
            if (addr_q[0] !== 32'hFFFF0000 || addr_q[1] !== 32'hFFFF0008 || addr_q[2] !== 32'hFFFF0000 || addr_q[3] !== 32'hFFFF0008)
                begin fails++; $display("FAIL wrrd_addrs: got %h %h %h %h", addr_q[0], addr_q[1], addr_q[2], addr_q[3]); end
        end
        asserts++;
        if (dat_t[18] !== (32'h12345678 ^ 32'hFFFF0008))
            begin fails++; $display("FAIL wrrd_b1beat0: got %h want %h", dat_t[18], 32'h12345678 ^ 32'hFFFF0008); end
        asserts++;
        if (err_count !== 16'd0) begin fails++; $display("FAIL wrrd_err: got %0d want 0", err_count); end
    endtask

    task automatic test_rd_check;
        corrupt_en = 1'b1; corrupt_addr = 32'hFFFF0000; corrupt_beat = 3;
        run_seq(2'b10, 32'hFFFF0000, 16'd2, 32'h12345678, 100);
        corrupt_en = 1'b0;
        asserts++;
        if (done_cycle !== 28) begin fails++; $display("FAIL rd_done_cycle: got %0d want 28", done_cycle); end
        asserts++;
        if (cmd_q.size() != 2 || cmd_q[0] !== 3'b001)
            begin fails++; $display("FAIL rd_cmds: got n=%0d want 2 READs", cmd_q.size()); end
        asserts++;
        if (err_count !== 16'd1) begin fails++; $display("FAIL rd_err: got %0d want 1", err_count); end
`ifdef SDRAM_SEQ_ERR_LOG_EN
        asserts++;
        if (err_valid !== 1'b1 || err_addr !== 32'hFFFF0000 || err_beat !== 3'd3 ||
            err_data !== ((32'h12345678 ^ 32'hFFFF0003) ^ 32'h1))
            begin fails++; $display("FAIL rd_errlog: got v=%b a=%h b=%0d d=%h", err_valid, err_addr, err_beat, err_data); end
`endif
    endtask

    task automatic test_refresh;
        run_seq(2'b11, 32'h00000100, 16'd3, 32'h0, 100);
        asserts++;
        if (done_cycle !== 17) begin fails++; $display("FAIL ref_done_cycle: got %0d want 17", done_cycle); end
        asserts++;
        if (cmd_q.size() != 3 || cmd_q[0] !== 3'b011 || cmd_q[1] !== 3'b011 || cmd_q[2] !== 3'b011)
            begin fails++; $display("FAIL ref_cmds: got n=%0d want 3 REFRESH", cmd_q.size()); end
        for (int i = 1; i <= 17; i++) begin
            if (dat_t[i] !== 32'h0 || end_t[i] !== 1'b0) begin
                asserts++; fails++;
                $display("FAIL ref_data_idle: cycle %0d got %h end=%b want 0", i, dat_t[i], end_t[i]);
                break;
            end
        end
    endtask

    task automatic test_wrap;
        run_seq(2'b01, 32'hFFFFFFF8, 16'd2, 32'hA5A5A5A5, 100);
        asserts++;
        if (done_cycle !== 28) begin fails++; $display("FAIL wrap_done_cycle: got %0d want 28", done_cycle); end
        asserts++;
        if (addr_q.size() != 2 || addr_q[1] !== 32'h0)
            begin fails++; $display("FAIL wrap_addr: got n=%0d want second addr 0", addr_q.size()); end
        asserts++;
        if (dat_t[12] !== 32'h5A5A5A5A || dat_t[18] !== 32'hA5A5A5A5)
            begin fails++; $display("FAIL wrap_data: got %h %h want 5A5A5A5A A5A5A5A5", dat_t[12], dat_t[18]); end
    endtask

    task automatic test_zero;
        run_seq(2'b01, 32'h40, 16'd0, 32'h0, 20);
        asserts++;
        if (done_cycle !== 1 || cmd_q.size() != 0 || busy_t[1] !== 1'b0)
            begin fails++; $display("FAIL zero_bursts: done@%0d cmds=%0d busy=%b want 1 0 0", done_cycle, cmd_q.size(), busy_t[1]); end
    endtask

    task automatic test_timeout;
        ack_en = 1'b0;
        run_seq(2'b01, 32'h80, 16'd1, 32'h0, 60);
        asserts++;
        if (done_cycle !== 17) begin fails++; $display("FAIL to_done_cycle: got %0d want 17", done_cycle); end
        asserts++;
        if (cmd_t[16] !== 3'b010 || to_t[16] !== 1'b0)
            begin fails++; $display("FAIL to_before: got cmd %h to %b want 2 0", cmd_t[16], to_t[16]); end
        asserts++;
        if (cmd_t[17] !== 3'b000 || to_t[17] !== 1'b1)
            begin fails++; $display("FAIL to_fire: got cmd %h to %b want 0 1", cmd_t[17], to_t[17]); end
        repeat (3) @(negedge CLK);
        asserts++;
        if (timeout !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", timeout); end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        @(negedge CLK);
        mode = 2'b01; base_addr = 32'hFFFF0000; num_bursts = 16'd2; seed = '0; start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (i == 1) begin
                asserts++;
                if (timeout !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", timeout); end
            end
        end
        asserts++;
        if (DATAIN !== 32'hFFFF0002) begin fails++; $display("FAIL mid_wdata: got %h want FFFF0002", DATAIN); end
        RESET_N = 1'b0;
        #1;
        asserts++;
        if ({CMD, ADDR, DATAIN, W_DATAEND, busy, done, timeout, err_count} !== '0)
            begin fails++; $display("FAIL mid_reset: got CMD=%h DATAIN=%h busy=%b done=%b want 0", CMD, DATAIN, busy, done); end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        asserts++;
        if (dones != 0 || busy !== 1'b0)
            begin fails++; $display("FAIL mid_no_done: got %0d dones busy=%b want 0 0", dones, busy); end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_wr_rd();
        test_rd_check();
        test_refresh();
        test_wrap();
        test_zero();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
